sap2_ctrl_seq: RTL and testbench

- Control sequencer for SAP2 mini; the initiator side of every control line the bus datapath obeys.
- Steps a T-state counter and decodes the 8-bit opcode from the instruction register plus accumulator/X flags.
- Emits one control word per cycle to drive pc, sc, mar, ram, mdr, ir, input, acc, alu, b, x and output port.
- Replaces the stub ctrl; clock and clear come in from outside rather than being generated here.

---
 rtl/sap2_ctrl_seq.sv | 188 ++++++++++++++++++
 tb/tb_sap2_ctrl_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sap2_ctrl_seq.sv
// SAP2 mini control sequencer: T-state counter plus opcode/flag decode into a 30-bit control word.
// Define SAP2_XJUMP_EN to add JXZ (10) and JXM (11); otherwise those opcodes are illegal.
module sap2_ctrl_seq #(
   parameter int T_MAX = 7
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [7:0]  ins,
   input  logic        am,
   input  logic        az,
   input  logic        xm,
   input  logic        xz,
   output logic [29:0] con,
   output logic [2:0]  t,
   output logic        hlt,
   output logic        ill
);

   localparam logic [29:0] CP  = 30'(1) << 29;
   localparam logic [29:0] EP  = 30'(1) << 28;
   localparam logic [29:0] LP  = 30'(1) << 27;
   localparam logic [29:0] ES  = 30'(1) << 25;
   localparam logic [29:0] LS  = 30'(1) << 24;
   localparam logic [29:0] LM  = 30'(1) << 23;
   localparam logic [29:0] CE  = 30'(1) << 22;
   localparam logic [29:0] WE  = 30'(1) << 21;
   localparam logic [29:0] LD  = 30'(1) << 20;
   localparam logic [29:0] LI  = 30'(1) << 18;
   localparam logic [29:0] EN  = 30'(1) << 15;
   localparam logic [29:0] LA  = 30'(1) << 14;
   localparam logic [29:0] EA  = 30'(1) << 13;
   localparam logic [29:0] S3  = 30'(1) << 12;
   localparam logic [29:0] S2  = 30'(1) << 11;
   localparam logic [29:0] S1  = 30'(1) << 10;
   localparam logic [29:0] S0  = 30'(1) << 9;
   localparam logic [29:0] CI  = 30'(1) << 7;
   localparam logic [29:0] EU  = 30'(1) << 6;
   localparam logic [29:0] LB  = 30'(1) << 5;
   localparam logic [29:0] LX  = 30'(1) << 4;
   localparam logic [29:0] INX = 30'(1) << 3;
   localparam logic [29:0] DEX = 30'(1) << 2;
   localparam logic [29:0] LO  = 30'(1) << 0;

   // Memory operand fetch shared by LDA/STA/ADD/SUB/LDX/CALL/jumps.
   localparam logic [29:0] RDA = EP | LM;
   localparam logic [29:0] RDB = CP | CE | LM;

   typedef enum logic [2:0] {
      S_HALT = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_T5   = 3'd5,
      S_T6   = 3'd6,
      S_T7   = 3'd7
   } state_t;

   state_t      st;
   logic [2:0]  len;
   logic        bad;
   logic        last;
   logic [29:0] fetch_w;
   logic [29:0] exec_w;

   always_comb begin
      fetch_w = '0;
      case (st)
         S_T1:    fetch_w = EP | LM;
         S_T2:    fetch_w = CP;
         S_T3:    fetch_w = CE | LI;
         default: fetch_w = '0;
      endcase
   end

   // Execute decode; only states T4..T7 produce a word, so T1..T3 never depend on ins.
   always_comb begin
      exec_w = '0;
      len    = 3'd4;
      bad    = 1'b0;
      case (ins)
         8'h00: len = 3'd4;
         8'h01: begin
            len = 3'd6;
            case (st)
               S_T4:    exec_w = RDA;
               S_T5:    exec_w = RDB;
               S_T6:    exec_w = CE | LA;
               default: exec_w = '0;
            endcase
         end
         8'h02: begin
            len = 3'd7;
            case (st)
               S_T4:    exec_w = RDA;
               S_T5:    exec_w = RDB;
               S_T6:    exec_w = EA | LD;
               S_T7:    exec_w = WE;
               default: exec_w = '0;
            endcase
         end
         8'h03, 8'h04: begin
            len = 3'd7;
            case (st)
               S_T4:    exec_w = RDA;
               S_T5:    exec_w = RDB;
               S_T6:    exec_w = CE | LB;
               S_T7:    exec_w = (ins == 8'h03) ? (EU | LA | S3 | S0 | CI) : (EU | LA | S2 | S1);
               default: exec_w = '0;
            endcase
         end
         8'h05, 8'h06, 8'h07: begin
            len = 3'd5;
            case (st)
               S_T4: exec_w = RDA;
               S_T5: begin
                  if (ins == 8'h05 || (ins == 8'h06 && az) || (ins == 8'h07 && am))
                     exec_w = CE | LP;
                  else
                     exec_w = CE | CP;
               end
               default: exec_w = '0;
            endcase
         end
         8'h08: begin
            len = 3'd7;
            case (st)
               S_T4:    exec_w = RDA;
               S_T5:    exec_w = CP;
               S_T6:    exec_w = EP | LS;
               S_T7:    exec_w = CE | LP;
               default: exec_w = '0;
            endcase
         end
         8'h09: if (st == S_T4) exec_w = ES | LP;
         8'h0A: if (st == S_T4) exec_w = EN | LA;
         8'h0B: if (st == S_T4) exec_w = EA | LO;
         8'h0C: begin
            len = 3'd6;
            case (st)
               S_T4:    exec_w = RDA;
               S_T5:    exec_w = RDB;
               S_T6:    exec_w = CE | LX;
               default: exec_w = '0;
            endcase
         end
         8'h0D: if (st == S_T4) exec_w = INX;
         8'h0E: if (st == S_T4) exec_w = DEX;
         8'h0F: len = 3'd4;
`ifdef SAP2_XJUMP_EN
         8'h10, 8'h11: begin
            len = 3'd5;
            case (st)
               S_T4: exec_w = RDA;
               S_T5: begin
                  if ((ins == 8'h10 && xz) || (ins == 8'h11 && xm))
                     exec_w = CE | LP;
                  else
                     exec_w = CE | CP;
               end
               default: exec_w = '0;
            endcase
         end
`endif
         default: bad = 1'b1;
      endcase
   end

   assign last = (st == state_t'(len)) || (int'(st) >= T_MAX);
   assign con  = fetch_w | exec_w;
   assign t    = st;
   assign hlt  = (st == S_HALT);
   assign ill  = bad && (st == S_T4);

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         st <= S_T1;
      else if (st == S_HALT)
         st <= S_HALT;
      else if (st == S_T4 && ins == 8'h0F)
         st <= S_HALT;
      else if (last)
         st <= S_T1;
      else
         st <= state_t'(st + 3'd1);
   end

endmodule

// File: tb/tb_sap2_ctrl_seq.sv
// Randomized bench for sap2_ctrl_seq against a table-driven instruction model.
module tb_sap2_ctrl_seq;

   logic        clk = 1'b0;
   logic        clr;
   logic [7:0]  ins;
   logic        am, az, xm, xz;
   logic [29:0] con;
   logic [2:0]  t;
   logic        hlt, ill;

   int tests = 0;
   int fails = 0;
   bit halted_m = 1'b0;

`ifdef SAP2_XJUMP_EN
   localparam bit XJ = 1'b1;
`else
   localparam bit XJ = 1'b0;
`endif

   localparam logic [29:0] CP  = 30'h2000_0000;
   localparam logic [29:0] EP  = 30'h1000_0000;
   localparam logic [29:0] LP  = 30'h0800_0000;
   localparam logic [29:0] ES  = 30'h0200_0000;
   localparam logic [29:0] LS  = 30'h0100_0000;
   localparam logic [29:0] LM  = 30'h0080_0000;
   localparam logic [29:0] CE  = 30'h0040_0000;
   localparam logic [29:0] WE  = 30'h0020_0000;
   localparam logic [29:0] LD  = 30'h0010_0000;
   localparam logic [29:0] LI  = 30'h0004_0000;
   localparam logic [29:0] EN  = 30'h0000_8000;
   localparam logic [29:0] LA  = 30'h0000_4000;
   localparam logic [29:0] EA  = 30'h0000_2000;
   localparam logic [29:0] S3  = 30'h0000_1000;
   localparam logic [29:0] S2  = 30'h0000_0800;
   localparam logic [29:0] S1  = 30'h0000_0400;
   localparam logic [29:0] S0  = 30'h0000_0200;
   localparam logic [29:0] CI  = 30'h0000_0080;
   localparam logic [29:0] EU  = 30'h0000_0040;
   localparam logic [29:0] LB  = 30'h0000_0020;
   localparam logic [29:0] LX  = 30'h0000_0010;
   localparam logic [29:0] INX = 30'h0000_0008;
   localparam logic [29:0] DEX = 30'h0000_0004;
   localparam logic [29:0] EX  = 30'h0000_0002;
   localparam logic [29:0] LO  = 30'h0000_0001;
   localparam logic [29:0] BUS = EP | ES | CE | EA | EN | EU | EX;

   sap2_ctrl_seq dut (
      .clk(clk), .clr(clr), .ins(ins),
      .am(am), .az(az), .xm(xm), .xz(xz),
      .con(con), .t(t), .hlt(hlt), .ill(ill)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0d ins=%h)", tag, got, exp, t, ins);
      end
   endtask

   function automatic int len_of(input logic [7:0] op);
      case (op)
         8'h01, 8'h0C:               return 6;
         8'h02, 8'h03, 8'h04, 8'h08: return 7;
         8'h05, 8'h06, 8'h07:        return 5;
         8'h10, 8'h11:               return XJ ? 5 : 4;
         default:                    return 4;
      endcase
   endfunction

   function automatic bit illegal(input logic [7:0] op);
      if (op <= 8'h0F) return 1'b0;
      if (XJ && (op == 8'h10 || op == 8'h11)) return 1'b0;
      return 1'b1;
   endfunction

   // f = {am, az, xm, xz}; ex[] lists the words of T4..T7 for each opcode.
   function automatic logic [29:0] exp_con(input logic [7:0] op, input int s, input logic [3:0] f);
      logic [29:0] ex [4];
      logic [29:0] rda;
      logic [29:0] rdb;
      rda = EP | LM;
      rdb = CP | CE | LM;
      ex  = '{default: '0};
      case (op)
         8'h01: ex = '{rda, rdb, CE | LA, '0};
         8'h02: ex = '{rda, rdb, EA | LD, WE};
         8'h03: ex = '{rda, rdb, CE | LB, EU | LA | S3 | S0 | CI};
         8'h04: ex = '{rda, rdb, CE | LB, EU | LA | S2 | S1};
         8'h05: ex = '{rda, CE | LP, '0, '0};
         8'h06: ex = '{rda, CE | (f[2] ? LP : CP), '0, '0};
         8'h07: ex = '{rda, CE | (f[3] ? LP : CP), '0, '0};
         8'h08: ex = '{rda, CP, EP | LS, CE | LP};
         8'h09: ex[0] = ES | LP;
         8'h0A: ex[0] = EN | LA;
         8'h0B: ex[0] = EA | LO;
         8'h0C: ex = '{rda, rdb, CE | LX, '0};
         8'h0D: ex[0] = INX;
         8'h0E: ex[0] = DEX;
         8'h10: if (XJ) ex = '{rda, CE | (f[0] ? LP : CP), '0, '0};
         8'h11: if (XJ) ex = '{rda, CE | (f[1] ? LP : CP), '0, '0};
         default: ex[0] = '0;
      endcase
      case (s)
         1: return EP | LM;
         2: return CP;
         3: return CE | LI;
         4, 5, 6, 7: return ex[s-4];
         default: return '0;
      endcase
   endfunction

   task automatic check_now(input logic [7:0] op, input int s, input bit halted);
      logic [29:0] e;
      e = halted ? 30'd0 : exp_con(op, s, {am, az, xm, xz});
      check("con", 32'(con), 32'(e));
      check("t", 32'(t), halted ? 32'd0 : 32'(s));
      check("hlt", 32'(hlt), 32'(halted));
      check("ill", 32'(ill), 32'(!halted && s == 4 && illegal(op)));
      check("bus", 32'($countones(con & BUS) > 1), 32'd0);
   endtask

   // Runs steps first.. of op; stops before the edge after step stop (stop=0: run to end).
   task automatic run_steps(input logic [7:0] op, input int fl, input int first, input int stop);
      int s;
      s = first;
      for (int k = 0; k < 8; k++) begin
         ins = (s < 4) ? 8'($urandom) : op;
         {am, az, xm, xz} = (fl < 0) ? 4'($urandom) : 4'(fl);
         #3;
         check_now(op, s, 1'b0);
         if (s == stop) return;
         @(posedge clk);
         #1;
         if (op == 8'h0F && s == 4) begin
            halted_m = 1'b1;
            return;
         end
         if (s == len_of(op)) return;
         s++;
      end
   endtask

   initial begin
      logic [7:0] op;
      int r;
      clr = 1'b1;
      ins = 8'h00;
      {am, az, xm, xz} = 4'h0;
      #2;
      check_now(8'h00, 1, 1'b0);
      @(posedge clk);
      #1;
      check("t_in_clr", 32'(t), 32'd1);
      clr = 1'b0;

      run_steps(8'h01, -1, 1, 0);
      run_steps(8'h06, 4'b0100, 1, 0);
      run_steps(8'h06, 4'b0000, 1, 0);
      run_steps(8'h07, 4'b1000, 1, 0);
      run_steps(8'h08, -1, 1, 0);
      run_steps(8'h09, -1, 1, 0);
      run_steps(8'h10, 4'b0001, 1, 0);
      run_steps(8'h11, 4'b0000, 1, 0);

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       op = 8'($urandom_range(0, 14));
         else if (r == 7) op = 8'(8'h10 + $urandom_range(0, 1));
         else             op = 8'($urandom_range(16, 255));
         run_steps(op, -1, 1, 0);
      end

      // Clear in the middle of ADD T6.
      run_steps(8'h03, -1, 1, 6);
      clr = 1'b1;
      #1;
      check_now(8'h00, 1, 1'b0);
      #2;
      clr = 1'b0;
      @(posedge clk);
      #1;
      run_steps(8'h05, -1, 2, 0);

      run_steps(8'h0F, -1, 1, 0);
      check("halted_model", 32'(halted_m), 32'd1);
      for (int n = 0; n < 20; n++) begin
         ins = 8'($urandom);
         {am, az, xm, xz} = 4'($urandom);
         #3;
         check_now(8'h0F, 0, 1'b1);
         @(posedge clk);
         #1;
      end
      clr = 1'b1;
      halted_m = 1'b0;
      #1;
      check_now(8'h00, 1, 1'b0);
      #1;
      clr = 1'b0;
      @(posedge clk);
      #1;
      run_steps(8'h03, -1, 2, 0);
      run_steps(8'h00, -1, 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
